// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: sub-word load/store engine in front of a word-wide data memory.
// Full-word stores are written directly. Narrower stores do a read-modify-write.
// Loads extract the addressed lanes and sign- or zero-extend them.
// Build option: define MEM_RMW_MISALIGN_TRAP_EN to reject misaligned requests.
// Without it, the low offset bits are forced down to the access size.
module mem_rmw_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic              iReqWe,
  input  logic [ADDR_W-1:0] iReqAddr,
  input  logic [1:0]        iReqSize,
  input  logic              iReqSigned,
  input  logic [DATA_W-1:0] iReqWData,
  output logic              oRespValid,
  output logic [DATA_W-1:0] oRespRData,
  output logic              oRespErr,
  output logic              oMemValid,
  input  logic              iMemReady,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemWData,
  input  logic              iMemRValid,
  input  logic [DATA_W-1:0] iMemRData
);

  localparam int         NB    = DATA_W / 8;
  localparam int         OFF   = $clog2(NB);
  localparam logic [1:0] MAXSZ = 2'(OFF);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [OFF-1:0]      off_q;
  logic [1:0]          size_q;
  logic                we_q;
  logic                sgn_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;

  logic [OFF-1:0]      req_off;
  logic [OFF-1:0]      req_mask;
  logic [OFF-1:0]      eff_off;
  logic                size_bad;
  logic                misalign;
  logic                full_store;

  // Byte-offset bits that must be zero for an access of 2^sz bytes.
  function automatic logic [OFF-1:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    m = 4'((4'd1 << sz) - 4'd1);
    return m[OFF-1:0];
  endfunction

  // Right-justify the addressed lanes and extend from the top extracted bit or with zeros.
  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                    input logic [OFF-1:0]    off,
                                                    input logic [1:0]        sz,
                                                    input logic              sgn);
    logic [DATA_W-1:0]        sh;
    logic signed [DATA_W-1:0] left;
    int unsigned              sa;
    sh   = word >> {off, 3'b000};
    sa   = DATA_W - (32'd8 << sz);
    left = sh << sa;
    if (sgn) return left >>> sa;
    return $unsigned(left) >> sa;
  endfunction

  // Replace the addressed lanes of word with the low bytes of wdata.
  function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                    input logic [DATA_W-1:0] wdata,
                                                    input logic [OFF-1:0]    off,
                                                    input logic [1:0]        sz);
    logic [DATA_W-1:0] m;
    int unsigned       sa;
    sa = DATA_W - (32'd8 << sz);
    m  = ({DATA_W{1'b1}} >> sa) << {off, 3'b000};
    return (word & ~m) | ((wdata << {off, 3'b000}) & m);
  endfunction

  assign req_off    = iReqAddr[OFF-1:0];
  assign req_mask   = size_mask(iReqSize);
  assign size_bad   = (iReqSize > MAXSZ);
  assign full_store = iReqWe && (iReqSize == MAXSZ);
`ifdef MEM_RMW_MISALIGN_TRAP_EN
  assign misalign   = |(req_off & req_mask);
  assign eff_off    = req_off;
`else
  assign misalign   = 1'b0;
  assign eff_off    = req_off & ~req_mask;
`endif

  assign oMemAddr   = addr_q;
  assign oMemWData  = word_q;
  assign oRespRData = (state == RESP) ? rdata_q : '0;
  assign oRespErr   = (state == RESP) && err_q;

  // State register; reset abandons any outstanding memory transaction.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    oReqReady  = 1'b0;
    oMemValid  = 1'b0;
    oMemWe     = 1'b0;
    oRespValid = 1'b0;
    case (state)
      IDLE: begin
        oReqReady = 1'b1;
        if (iReqValid) begin
          if (size_bad || misalign) state_nxt = RESP;
          else if (full_store)      state_nxt = WR_REQ;
          else                      state_nxt = RD_REQ;
        end
      end
      RD_REQ: begin
        oMemValid = 1'b1;
        if (iMemReady) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (iMemRValid) state_nxt = we_q ? WR_REQ : RESP;
      end
      WR_REQ: begin
        oMemValid = 1'b1;
        oMemWe    = 1'b1;
        if (iMemReady) state_nxt = RESP;
      end
      RESP: begin
        oRespValid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, then load extraction or store merge when read data returns.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      addr_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == IDLE && iReqValid) begin
      addr_q  <= {iReqAddr[ADDR_W-1:OFF], {OFF{1'b0}}};
      off_q   <= eff_off;
      size_q  <= iReqSize;
      we_q    <= iReqWe;
      sgn_q   <= iReqSigned;
      wdata_q <= iReqWData;
      word_q  <= full_store ? iReqWData : '0;
      rdata_q <= '0;
      err_q   <= size_bad || misalign;
    end else if (state == RD_WAIT && iMemRValid) begin
      if (we_q) word_q  <= merge_store(iMemRData, wdata_q, off_q, size_q);
      else      rdata_q <= load_extend(iMemRData, off_q, size_q, sgn_q);
    end
  end

endmodule

// File: tb/tb_mem_rmw_unit.sv
// Directed bench for mem_rmw_unit with a memory responder and response/command scoreboards.
`timescale 1ns/1ps
module tb_mem_rmw_unit;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          iClk = 1'b0;
  logic          iRst_n = 1'b0;
  logic          iReqValid = 1'b0;
  logic          oReqReady;
  logic          iReqWe = 1'b0;
  logic [AW-1:0] iReqAddr = '0;
  logic [1:0]    iReqSize = '0;
  logic          iReqSigned = 1'b0;
  logic [DW-1:0] iReqWData = '0;
  logic          oRespValid;
  logic [DW-1:0] oRespRData;
  logic          oRespErr;
  logic          oMemValid;
  logic          iMemReady;
  logic          oMemWe;
  logic [AW-1:0] oMemAddr;
  logic [DW-1:0] oMemWData;
  logic          iMemRValid;
  logic [DW-1:0] iMemRData;

  mem_rmw_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iReqValid(iReqValid), .oReqReady(oReqReady), .iReqWe(iReqWe),
    .iReqAddr(iReqAddr), .iReqSize(iReqSize), .iReqSigned(iReqSigned),
    .iReqWData(iReqWData), .oRespValid(oRespValid), .oRespRData(oRespRData),
    .oRespErr(oRespErr), .oMemValid(oMemValid), .iMemReady(iMemReady),
    .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .iMemRValid(iMemRValid), .iMemRData(iMemRData)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] rdata; logic err; } resp_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  resp_t       resp_q[$];
  logic [31:0] rd_q[$];
  wr_t         wr_q[$];
  logic [31:0] mem [0:63];

  int          rd_lat = 1;
  int          rd_cnt = 0;
  logic [31:0] rd_data = '0;
  int          stall_load = 0;
  bit          stall_go = 1'b0;
  bit          stall_seen = 1'b0;
  int          stall_left = 0;

  assign iMemReady  = (stall_left == 0);
  assign iMemRValid = (rd_cnt == 1);
  assign iMemRData  = rd_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: reads return after rd_lat cycles, commands checked at handshake.
  always @(posedge iClk) begin
    if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
    if (stall_go != stall_seen) begin
      stall_seen <= stall_go;
      stall_left <= stall_load;
    end else if (oMemValid && stall_left != 0) begin
      stall_left <= stall_left - 1;
    end
    if (iRst_n && oMemValid && iMemReady) begin
      if (!oMemWe) begin
        rd_cnt  <= rd_lat;
        rd_data <= mem[oMemAddr[7:2]];
        if (rd_q.size() == 0) check("unexpected_read", {63'b0, oMemValid}, 64'd0);
        else check("read_addr", 64'(oMemAddr), 64'(rd_q.pop_front()));
      end else begin
        if (wr_q.size() == 0) check("unexpected_write", {63'b0, oMemValid}, 64'd0);
        else begin
          wr_t w;
          w = wr_q.pop_front();
          check("write_addr", 64'(oMemAddr), 64'(w.a));
          check("write_data", 64'(oMemWData), 64'(w.d));
        end
      end
    end
  end

  // Response scoreboard.
  always @(negedge iClk) begin
    if (iRst_n && oRespValid) begin
      if (resp_q.size() == 0) check("unexpected_resp", {63'b0, oRespValid}, 64'd0);
      else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_rdata", 64'(oRespRData), 64'(e.rdata));
        check("resp_err", {63'b0, oRespErr}, {63'b0, e.err});
      end
    end
  end

  // Command signals must hold while stalled.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wd;
  logic        prev_we;
  always @(negedge iClk) begin
    if (!iRst_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_valid", {63'b0, oMemValid}, 64'd1);
        check("hold_addr", 64'(oMemAddr), 64'(prev_addr));
        check("hold_we", {63'b0, oMemWe}, {63'b0, prev_we});
        check("hold_wdata", 64'(oMemWData), 64'(prev_wd));
      end
      prev_stall = oMemValid && !iMemReady;
      prev_addr  = oMemAddr;
      prev_we    = oMemWe;
      prev_wd    = oMemWData;
    end
  end

  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [1:0] sz, input logic sgn, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                        output int first_mem);
    int lat;
    @(posedge iClk); #1;
    check({tag, "_ready"}, {63'b0, oReqReady}, 64'd1);
    iReqValid = 1'b1; iReqWe = we; iReqAddr = addr; iReqSize = sz;
    iReqSigned = sgn; iReqWData = wd;
    resp_q.push_back('{exp_rd, exp_err});
    @(posedge iClk); #1;
    iReqValid = 1'b0; iReqWData = '0;
    lat = 0; first_mem = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge iClk);
      if (oMemValid && first_mem == 0) first_mem = c;
      if (oRespValid) lat = c;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    int fm;
    int cnt;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    // Reset state
    repeat (2) @(negedge iClk);
    check("rst_reqready", {63'b0, oReqReady}, 64'd1);
    check("rst_respvalid", {63'b0, oRespValid}, 64'd0);
    check("rst_resperr", {63'b0, oRespErr}, 64'd0);
    check("rst_rdata", 64'(oRespRData), 64'd0);
    check("rst_memvalid", {63'b0, oMemValid}, 64'd0);
    check("rst_memwe", {63'b0, oMemWe}, 64'd0);
    check("rst_memaddr", 64'(oMemAddr), 64'd0);
    check("rst_memwdata", 64'(oMemWData), 64'd0);
    @(posedge iClk); #1 iRst_n = 1'b1;

    // Byte store read-modify-write
    mem[0] = 32'h11223344;
    rd_q.push_back(32'h1000); wr_q.push_back('{32'h1000, 32'h1122AB44});
    do_req("st_b", 1'b1, 32'h1001, 2'd0, 1'b0, 32'hAB, 32'h0, 1'b0, 4, fm);
    check("st_b_first_mem", 64'(fm), 64'd1);

    // Full-word store, no read
    wr_q.push_back('{32'h2000, 32'hDEADBEEF});
    do_req("st_w", 1'b1, 32'h2000, 2'd2, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2, fm);
    check("st_w_first_mem", 64'(fm), 64'd1);

    // Loads
    mem[0] = 32'h80011234;
    rd_q.push_back(32'h0);
    do_req("ld_hs", 1'b0, 32'h0002, 2'd1, 1'b1, 32'h0, 32'hFFFF8001, 1'b0, 3, fm);
    rd_q.push_back(32'h0);
    do_req("ld_hu", 1'b0, 32'h0002, 2'd1, 1'b0, 32'h0, 32'h00008001, 1'b0, 3, fm);
    rd_q.push_back(32'h0);
    do_req("ld_bs", 1'b0, 32'h0000, 2'd0, 1'b1, 32'h0, 32'h00000034, 1'b0, 3, fm);
    mem[1] = 32'hF0000000;
    rd_q.push_back(32'h4);
    do_req("ld_b3s", 1'b0, 32'h0007, 2'd0, 1'b1, 32'h0, 32'hFFFFFFF0, 1'b0, 3, fm);
    mem[2] = 32'hCAFEF00D;
    rd_q.push_back(32'h8);
    do_req("ld_w", 1'b0, 32'h0008, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 3, fm);

    // Sub-word stores with upper wdata bits that must be ignored
    mem[0] = 32'h11223344;
    rd_q.push_back(32'h0); wr_q.push_back('{32'h0, 32'h77223344});
    do_req("st_b3", 1'b1, 32'h0003, 2'd0, 1'b0, 32'hFFFFFF77, 32'h0, 1'b0, 4, fm);
    rd_q.push_back(32'h0); wr_q.push_back('{32'h0, 32'hABCD3344});
    do_req("st_h2", 1'b1, 32'h0002, 2'd1, 1'b0, 32'h1234ABCD, 32'h0, 1'b0, 4, fm);

    // Misaligned half-word store
    mem[0] = 32'hAABBCCDD;
`ifdef MEM_RMW_MISALIGN_TRAP_EN
    do_req("st_h1", 1'b1, 32'h0001, 2'd1, 1'b0, 32'h5566, 32'h0, 1'b1, 1, fm);
    check("st_h1_no_mem", 64'(fm), 64'd0);
`else
    rd_q.push_back(32'h0); wr_q.push_back('{32'h0, 32'hAABB5566});
    do_req("st_h1", 1'b1, 32'h0001, 2'd1, 1'b0, 32'h5566, 32'h0, 1'b0, 4, fm);
`endif

    // Dword request on a 32-bit memory
    mem[4] = 32'h12345678;
    do_req("ld_d", 1'b0, 32'h0010, 2'd3, 1'b1, 32'h0, 32'h0, 1'b1, 1, fm);
    check("ld_d_no_mem", 64'(fm), 64'd0);

    // Backpressure: three stalled cycles on the read command
    mem[0] = 32'h80011234;
    stall_load = 3; stall_go = ~stall_go;
    rd_q.push_back(32'h0);
    do_req("ld_bp", 1'b0, 32'h0002, 2'd1, 1'b0, 32'h0, 32'h00008001, 1'b0, 6, fm);

    // Reset during RD_WAIT, late read data afterwards
    rd_lat = 4;
    rd_q.push_back(32'h0);
    @(posedge iClk); #1;
    iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 32'h0; iReqSize = 2'd2; iReqSigned = 1'b0;
    @(posedge iClk); #1 iReqValid = 1'b0;
    @(posedge iClk); #1;
    @(negedge iClk);
    check("rw_memvalid", {63'b0, oMemValid}, 64'd0);
    check("rw_reqready", {63'b0, oReqReady}, 64'd0);
    #1 iRst_n = 1'b0;
    #1 check("rst_mid_reqready", {63'b0, oReqReady}, 64'd1);
    @(posedge iClk); #1 iRst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge iClk);
      if (oRespValid) cnt++;
    end
    check("rst_mid_no_resp", 64'(cnt), 64'd0);
    check("rst_mid_ready_after", {63'b0, oReqReady}, 64'd1);
    rd_lat = 1;

    // Normal operation resumes
    mem[3] = 32'h0000A5C3;
    rd_q.push_back(32'hC);
    do_req("ld_after", 1'b0, 32'h000C, 2'd0, 1'b1, 32'h0, 32'hFFFFFFC3, 1'b0, 3, fm);

    repeat (3) @(negedge iClk);
    check("resp_q_empty", 64'(resp_q.size()), 64'd0);
    check("rd_q_empty", 64'(rd_q.size()), 64'd0);
    check("wr_q_empty", 64'(wr_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
